// File: rtl/gray_writer.sv
// Gray-pixel write-back buffer: FIFO + sequential write addresses per frame.
// Optional frame checksum is built when GRAY_WR_CHECKSUM_EN is defined.
module gray_writer #(
  parameter int ADDRWIDTH  = 18,
  parameter int DATAWIDTH  = 8,
  parameter int PIXELS     = 262144,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 pix_valid,
  input  logic [DATAWIDTH-1:0] pix_data,
  output logic                 pix_ready,
  input  logic                 mem_ready,
  output logic                 WR_EN,
  output logic [ADDRWIDTH-1:0] WR_ADDR,
  output logic [DATAWIDTH-1:0] WR_DATA,
  output logic                 busy,
  output logic                 Done_full,
  output logic [31:0]          CHECKSUM
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDRWIDTH:0] PIX = (ADDRWIDTH+1)'(PIXELS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q;
  logic                 busy_q, done_q;
  logic [ADDRWIDTH:0]   acc_q, acc_d;
  logic [ADDRWIDTH:0]   wcnt_q, wcnt_d;
  logic [PW:0]          wp_q, wp_d, rp_q, rp_d;
  logic [DATAWIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                 wr_en_q;
  logic [ADDRWIDTH-1:0] wr_addr_q;
  logic [DATAWIDTH-1:0] wr_data_q;
  logic                 run, empty, full, push, pop, go;

  assign run   = (state_q == RUN);
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[PW] != rp_q[PW]) &&
                 (wp_q[PW-1:0] == rp_q[PW-1:0]);

  assign pix_ready = run && !full && (acc_q < PIX);
  assign push      = pix_valid && pix_ready;
  assign pop       = run && !empty && mem_ready;
  assign go        = start && !run;

  always_comb begin
    acc_d  = acc_q;
    wcnt_d = wcnt_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    if (push) begin
      acc_d = acc_q + 1'b1;
      wp_d  = wp_q + 1'b1;
    end
    if (pop) begin
      wcnt_d = wcnt_q + 1'b1;
      rp_d   = rp_q + 1'b1;
    end
    // a new frame starts from an empty FIFO and zeroed counters
    if (go) begin
      acc_d  = '0;
      wcnt_d = '0;
      wp_d   = '0;
      rp_d   = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      acc_q     <= '0;
      wcnt_q    <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      acc_q   <= acc_d;
      wcnt_q  <= wcnt_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      wr_en_q <= pop;
      if (pop) begin
        wr_addr_q <= wcnt_q[ADDRWIDTH-1:0];
        wr_data_q <= mem_q[rp_q[PW-1:0]];
      end
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          if (wcnt_q == PIX) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wp_q[PW-1:0]] <= pix_data;
    end
  end

`ifdef GRAY_WR_CHECKSUM_EN
  logic [31:0] csum_q;

  always_ff @(posedge CLK) begin
    if (RST || go) begin
      csum_q <= '0;
    end else if (wr_en_q) begin
      csum_q <= csum_q + 32'(wr_data_q);
    end
  end

  assign CHECKSUM = csum_q;
`else
  assign CHECKSUM = '0;
`endif

  assign WR_EN     = wr_en_q;
  assign WR_ADDR   = wr_addr_q;
  assign WR_DATA   = wr_data_q;
  assign busy      = busy_q;
  assign Done_full = done_q;

endmodule
